// File: rtl/md_unit_ctrl.sv
// HI/LO multiply/divide sequencer: fixed-latency busy window, owns HI/LO, raises D-stage stall.
// Optional MD_DIVZERO_FAST_EN: divide-by-zero finishes after a single busy cycle.
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic        md_cancel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_use_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic            pend_we_q, pend_we_d;

  logic        is_start_op, is_div, div_zero, start;
  logic [63:0] mul_s, mul_u;
  logic signed [32:0] dvd_s, dvs_s;
  logic [31:0] quo_s, rem_s, dvs_u, quo_u, rem_u;
  logic [31:0] res_hi, res_lo;

  assign is_start_op = (md_op >= 3'd1) && (md_op <= 3'd4);
  assign is_div      = (md_op == 3'd3) || (md_op == 3'd4);
  assign div_zero    = (rt_val == 32'd0);
  assign start       = is_start_op && !md_cancel && (state_q == StIdle);

  assign mul_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign mul_u = {32'd0, rs_val} * {32'd0, rt_val};

  // 33-bit signed divide so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
  assign dvd_s = $signed({rs_val[31], rs_val});
  assign dvs_s = div_zero ? 33'sd1 : $signed({rt_val[31], rt_val});
  assign quo_s = 32'(dvd_s / dvs_s);
  assign rem_s = 32'(dvd_s % dvs_s);
  assign dvs_u = div_zero ? 32'd1 : rt_val;
  assign quo_u = rs_val / dvs_u;
  assign rem_u = rs_val % dvs_u;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    unique case (md_op)
      3'd1:    {res_hi, res_lo} = mul_s;
      3'd2:    {res_hi, res_lo} = mul_u;
      3'd3:    {res_hi, res_lo} = {rem_s, quo_s};
      3'd4:    {res_hi, res_lo} = {rem_u, quo_u};
      default: {res_hi, res_lo} = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StBusy;
      StBusy:  if (cnt_q == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    if (start) begin
      pend_hi_d = res_hi;
      pend_lo_d = res_lo;
      pend_we_d = !(is_div && div_zero);
      if (!is_div) begin
        cnt_d = CntW'(MULT_CYCLES - 1);
      end else begin
`ifdef MD_DIVZERO_FAST_EN
        cnt_d = div_zero ? '0 : CntW'(DIV_CYCLES - 1);
`else
        cnt_d = CntW'(DIV_CYCLES - 1);
`endif
      end
    end else if (state_q == StBusy) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (pend_we_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (!md_cancel) begin
      if (md_op == 3'd5) hi_d = rs_val;
      if (md_op == 3'd6) lo_d = rs_val;
    end
  end

  always_comb begin
    busy  = (state_q == StBusy);
    stall = d_use_md && (busy || is_start_op);
    hi    = hi_q;
    lo    = lo_q;
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed self-checking bench for md_unit_ctrl (honours MD_DIVZERO_FAST_EN if defined).
module tb_md_unit_ctrl;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;
`ifdef MD_DIVZERO_FAST_EN
  localparam int unsigned DivZeroN = 1;
`else
  localparam int unsigned DivZeroN = DivN;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op;
  logic        md_cancel;
  logic [31:0] rs_val, rt_val;
  logic        d_use_md;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  md_unit_ctrl #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .md_op    (md_op),
    .md_cancel(md_cancel),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .d_use_md (d_use_md),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op with d_use_md high, then expect n busy/stall cycles and the final HI:LO.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [63:0] exp_hilo);
    md_op = op; rs_val = a; rt_val = b; d_use_md = 1'b1;
    #1;
    check({tag, " start stall"}, 64'(stall), 64'd1);
    check({tag, " start busy"}, 64'(busy), 64'd0);
    step();
    md_op = 3'd0;
    #1;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s busy[%0d]", tag, i), 64'(busy), 64'd1);
      check($sformatf("%s stall[%0d]", tag, i), 64'(stall), 64'd1);
      step();
    end
    check({tag, " done busy"}, 64'(busy), 64'd0);
    check({tag, " done stall"}, 64'(stall), 64'd0);
    check({tag, " hi:lo"}, {hi, lo}, exp_hilo);
    d_use_md = 1'b0;
  endtask

  initial begin
    reset = 1'b1; md_op = 3'd0; md_cancel = 1'b0; rs_val = '0; rt_val = '0; d_use_md = 1'b0;
    step(); step();
    reset = 1'b0;
    d_use_md = 1'b1;
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset stall", 64'(stall), 64'd0);
    check("reset hi:lo", {hi, lo}, 64'd0);
    d_use_md = 1'b0;

    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, MultN, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MultN, 64'hFFFF_FFFE_0000_0001);
    run_op("div -7/2", 3'd3, 32'hFFFF_FFF9, 32'd2, DivN, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div 7/-2", 3'd3, 32'd7, 32'hFFFF_FFFE, DivN, 64'h0000_0001_FFFF_FFFD);
    run_op("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DivN, 64'h0000_0000_8000_0000);
    run_op("divu", 3'd4, 32'd100, 32'd7, DivN, 64'h0000_0002_0000_000E);

    // mthi / mtlo: write next edge, never busy
    md_op = 3'd5; rs_val = 32'h1234_5678;
    step();
    md_op = 3'd0;
    #1;
    check("mthi hi", 64'(hi), 64'h1234_5678);
    check("mthi busy", 64'(busy), 64'd0);
    md_op = 3'd6; rs_val = 32'hCAFE_BABE;
    step();
    md_op = 3'd0;
    #1;
    check("mtlo hi:lo", {hi, lo}, 64'h1234_5678_CAFE_BABE);

    run_op("div0", 3'd3, 32'd55, 32'd0, DivZeroN, 64'h1234_5678_CAFE_BABE);
    run_op("divu0", 3'd4, 32'd55, 32'd0, DivZeroN, 64'h1234_5678_CAFE_BABE);

    // cancelled div and cancelled mthi are dropped
    md_op = 3'd3; rs_val = 32'd9; rt_val = 32'd3; md_cancel = 1'b1;
    step();
    md_op = 3'd0;
    #1;
    check("cancel div busy", 64'(busy), 64'd0);
    md_op = 3'd5; rs_val = 32'hDEAD_BEEF;
    step();
    md_op = 3'd0; md_cancel = 1'b0;
    #1;
    check("cancel busy", 64'(busy), 64'd0);
    check("cancel hi:lo", {hi, lo}, 64'h1234_5678_CAFE_BABE);

    // mtlo arriving while busy is ignored
    md_op = 3'd2; rs_val = 32'd3; rt_val = 32'd4;
    step();
    md_op = 3'd6; rs_val = 32'hDEAD;
    step();
    md_op = 3'd0;
    for (int i = 0; i < int'(MultN); i++) step();
    check("busy op ignored hi:lo", {hi, lo}, 64'h0000_0000_0000_000C);
    check("busy op ignored busy", 64'(busy), 64'd0);

    // reset mid-div discards the op and clears HI/LO
    md_op = 3'd4; rs_val = 32'd20; rt_val = 32'd3;
    step();
    md_op = 3'd0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("mid reset busy", 64'(busy), 64'd0);
    check("mid reset hi:lo", {hi, lo}, 64'd0);
    for (int i = 0; i < int'(DivN); i++) step();
    check("mid reset stays clear", {hi, lo}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
